// File: rtl/fb_arbiter_if.sv
// Pixel-RAM arbitration bus: VGA scan-out reader, two game-logic requesters, single RAM port.
// With FB_DOUBLE_BUFFER_EN defined, frame-swap signals appear and ram_addr gains a bank MSB.
interface fb_arbiter_if #(
  parameter int ROW_W = 9,
  parameter int COL_W = 10,
  parameter int DW    = 12
);
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int AW = ROW_W + COL_W + 1;
`else
  localparam int AW = ROW_W + COL_W;
`endif

  logic             vga_rd;
  logic [ROW_W-1:0] vga_row;
  logic [COL_W-1:0] vga_col;
  logic [DW-1:0]    vga_rdata;
  logic             vga_rvalid;

  logic             r0_req;
  logic             r0_we;
  logic [ROW_W-1:0] r0_row;
  logic [COL_W-1:0] r0_col;
  logic [DW-1:0]    r0_wdata;
  logic             r0_gnt;
  logic             r0_rvalid;
  logic [DW-1:0]    r0_rdata;
  logic             r0_starve;

  logic             r1_req;
  logic             r1_we;
  logic [ROW_W-1:0] r1_row;
  logic [COL_W-1:0] r1_col;
  logic [DW-1:0]    r1_wdata;
  logic             r1_gnt;
  logic             r1_rvalid;
  logic [DW-1:0]    r1_rdata;
  logic             r1_starve;

  logic             ram_en;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_wdata;
  logic [DW-1:0]    ram_rdata;

`ifdef FB_DOUBLE_BUFFER_EN
  logic             swap_req;
  logic             frame_start;
  logic             front_sel;
  logic             swap_done;
`endif

  modport slave (
    input  vga_rd, vga_row, vga_col,
    output vga_rdata, vga_rvalid,
    input  r0_req, r0_we, r0_row, r0_col, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata, r0_starve,
    input  r1_req, r1_we, r1_row, r1_col, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata, r1_starve,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
`ifdef FB_DOUBLE_BUFFER_EN
    , input swap_req, frame_start
    , output front_sel, swap_done
`endif
  );

  modport master (
    output vga_rd, vga_row, vga_col,
    input  vga_rdata, vga_rvalid,
    output r0_req, r0_we, r0_row, r0_col, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata, r0_starve,
    output r1_req, r1_we, r1_row, r1_col, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata, r1_starve,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
`ifdef FB_DOUBLE_BUFFER_EN
    , output swap_req, frame_start
    , input front_sel, swap_done
`endif
  );
endinterface

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: VGA reads win outright, r0/r1 share the blanking cycles round-robin.
// Optional double buffering (front/back bank swap on frame start) under FB_DOUBLE_BUFFER_EN.
module fb_arbiter #(
  parameter int ROW_W        = 9,
  parameter int COL_W        = 10,
  parameter int DW           = 12,
  parameter int STARVE_LIMIT = 800
) (
  input  logic         vga_clk,
  input  logic         rst,
  fb_arbiter_if.slave  bus
);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

  typedef enum logic [1:0] {SLOT_NONE, SLOT_VGA, SLOT_R0, SLOT_R1} slot_e;

  slot_e            owner;
  slot_e            rd_tag_q, rd_tag_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]    wait0_q, wait0_d, wait1_q, wait1_d;
  logic             starve0_q, starve0_d, starve1_q, starve1_d;
  logic [ROW_W-1:0] row_mux;
  logic [COL_W-1:0] col_mux;
`ifdef FB_DOUBLE_BUFFER_EN
  logic             front_sel_q, front_sel_d;
  logic             swap_pend_q, swap_pend_d;
  logic             swap_done_q, swap_done_d;
  logic             bank_mux;
`endif

  always_comb begin
    owner = SLOT_NONE;
    if (rst)                            owner = SLOT_NONE;
    else if (bus.vga_rd)                owner = SLOT_VGA;
    else if (bus.r0_req && bus.r1_req)  owner = rr_ptr_q ? SLOT_R1 : SLOT_R0;
    else if (bus.r0_req)                owner = SLOT_R0;
    else if (bus.r1_req)                owner = SLOT_R1;
  end

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.r0_gnt    = 1'b0;
    bus.r1_gnt    = 1'b0;
    row_mux       = '0;
    col_mux       = '0;
`ifdef FB_DOUBLE_BUFFER_EN
    bank_mux      = 1'b0;
`endif
    case (owner)
      SLOT_VGA: begin
        bus.ram_en = 1'b1;
        row_mux    = bus.vga_row;
        col_mux    = bus.vga_col;
`ifdef FB_DOUBLE_BUFFER_EN
        bank_mux   = front_sel_q;
`endif
      end
      SLOT_R0: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = bus.r0_we;
        bus.ram_wdata = bus.r0_wdata;
        bus.r0_gnt    = 1'b1;
        row_mux       = bus.r0_row;
        col_mux       = bus.r0_col;
`ifdef FB_DOUBLE_BUFFER_EN
        bank_mux      = ~front_sel_q;
`endif
      end
      SLOT_R1: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = bus.r1_we;
        bus.ram_wdata = bus.r1_wdata;
        bus.r1_gnt    = 1'b1;
        row_mux       = bus.r1_row;
        col_mux       = bus.r1_col;
`ifdef FB_DOUBLE_BUFFER_EN
        bank_mux      = ~front_sel_q;
`endif
      end
      default: ;
    endcase
`ifdef FB_DOUBLE_BUFFER_EN
    bus.ram_addr = {bank_mux, row_mux, col_mux};
`else
    bus.ram_addr = {row_mux, col_mux};
`endif
  end

  // Tag each read slot with its owner so the 1-cycle RAM return is steered back.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rd_tag_d = SLOT_NONE;
    case (owner)
      SLOT_VGA: rd_tag_d = SLOT_VGA;
      SLOT_R0: begin
        rr_ptr_d = 1'b1;
        if (!bus.r0_we) rd_tag_d = SLOT_R0;
      end
      SLOT_R1: begin
        rr_ptr_d = 1'b0;
        if (!bus.r1_we) rd_tag_d = SLOT_R1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait0_d = '0;
    wait1_d = '0;
    if (bus.r0_req && !bus.r0_gnt)
      wait0_d = (wait0_q == WAIT_MAX) ? wait0_q : wait0_q + 1'b1;
    if (bus.r1_req && !bus.r1_gnt)
      wait1_d = (wait1_q == WAIT_MAX) ? wait1_q : wait1_q + 1'b1;
    starve0_d = (wait0_d == WAIT_MAX);
    starve1_d = (wait1_d == WAIT_MAX);
  end

`ifdef FB_DOUBLE_BUFFER_EN
  always_comb begin
    swap_pend_d = swap_pend_q | bus.swap_req;
    front_sel_d = front_sel_q;
    swap_done_d = 1'b0;
    if (bus.frame_start && swap_pend_d) begin
      front_sel_d = ~front_sel_q;
      swap_pend_d = 1'b0;
      swap_done_d = 1'b1;
    end
  end

  assign bus.front_sel = front_sel_q;
  assign bus.swap_done = swap_done_q;
`endif

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      rd_tag_q  <= SLOT_NONE;
      rr_ptr_q  <= 1'b0;
      wait0_q   <= '0;
      wait1_q   <= '0;
      starve0_q <= 1'b0;
      starve1_q <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
      front_sel_q <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
`endif
    end else begin
      rd_tag_q  <= rd_tag_d;
      rr_ptr_q  <= rr_ptr_d;
      wait0_q   <= wait0_d;
      wait1_q   <= wait1_d;
      starve0_q <= starve0_d;
      starve1_q <= starve1_d;
`ifdef FB_DOUBLE_BUFFER_EN
      front_sel_q <= front_sel_d;
      swap_pend_q <= swap_pend_d;
      swap_done_q <= swap_done_d;
`endif
    end
  end

  // Gated by rst so a read issued just before reset never returns during the reset cycle.
  assign bus.vga_rvalid = (rd_tag_q == SLOT_VGA) && !rst;
  assign bus.r0_rvalid  = (rd_tag_q == SLOT_R0)  && !rst;
  assign bus.r1_rvalid  = (rd_tag_q == SLOT_R1)  && !rst;
  assign bus.vga_rdata  = bus.ram_rdata;
  assign bus.r0_rdata   = bus.ram_rdata;
  assign bus.r1_rdata   = bus.ram_rdata;
  assign bus.r0_starve  = starve0_q && !rst;
  assign bus.r1_starve  = starve1_q && !rst;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference of the arbitration rules and a shadow copy of pixel memory.
module tb_fb_arbiter;
  localparam int ROW_W = 9;
  localparam int COL_W = 10;
  localparam int DW    = 12;
  localparam int LIMIT = 800;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int AW = ROW_W + COL_W + 1;
`else
  localparam int AW = ROW_W + COL_W;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fb_arbiter_if #(.ROW_W(ROW_W), .COL_W(COL_W), .DW(DW)) bus ();

  fb_arbiter #(
    .ROW_W(ROW_W), .COL_W(COL_W), .DW(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .vga_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] pix_init(int a);
    return DW'((a * 7) ^ (a >> 10) ^ 12'h5A5);
  endfunction

  // Single-port synchronous RAM, write-first, 1-cycle read latency.
  bit [DW-1:0] ram_mem [0:(1<<AW)-1];
  bit          ram_wr  [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        ram_mem[bus.ram_addr] <= bus.ram_wdata;
        ram_wr[bus.ram_addr]  <= 1'b1;
        bus.ram_rdata         <= bus.ram_wdata;
      end else begin
        bus.ram_rdata <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr] : pix_init(int'(bus.ram_addr));
      end
    end
  end

  // Reference state
  bit [DW-1:0] shadow [int];
  int          pref;      // requester index preferred on a tie
  int          pend;      // owner of last cycle's read: 0 none, 1 vga, 2 r0, 3 r1
  logic [DW-1:0] pdata;
  int          cnt0, cnt1;
  bit          g0, g1;
`ifdef FB_DOUBLE_BUFFER_EN
  int          m_front, m_pend, m_done;
`endif

  function automatic logic [DW-1:0] shadow_rd(int a);
    return shadow.exists(a) ? shadow[a] : pix_init(a);
  endfunction

  function automatic int addr_of(int bank, int row, int col);
    return (bank << (ROW_W + COL_W)) | (row << COL_W) | col;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pref = 0; pend = 0; cnt0 = 0; cnt1 = 0;
`ifdef FB_DOUBLE_BUFFER_EN
    m_front = 0; m_pend = 0; m_done = 0;
`endif
  endtask

  // One clock: check all outputs for the current inputs, then advance the reference.
  task automatic step();
    int own, a, bank_v, bank_r;
    bit we;
    logic [DW-1:0] wd;
    #2;
    own = 0;
    if (rst)                          own = 0;
    else if (bus.vga_rd)              own = 1;
    else if (bus.r0_req && bus.r1_req) own = 2 + pref;
    else if (bus.r0_req)              own = 2;
    else if (bus.r1_req)              own = 3;
`ifdef FB_DOUBLE_BUFFER_EN
    bank_v = m_front;
    bank_r = 1 - m_front;
`else
    bank_v = 0;
    bank_r = 0;
`endif
    a = 0; we = 1'b0; wd = '0;
    case (own)
      1: a = addr_of(bank_v, int'(bus.vga_row), int'(bus.vga_col));
      2: begin a = addr_of(bank_r, int'(bus.r0_row), int'(bus.r0_col)); we = bus.r0_we; wd = bus.r0_wdata; end
      3: begin a = addr_of(bank_r, int'(bus.r1_row), int'(bus.r1_col)); we = bus.r1_we; wd = bus.r1_wdata; end
      default: ;
    endcase
    chk("r0_gnt", bus.r0_gnt, own == 2);
    chk("r1_gnt", bus.r1_gnt, own == 3);
    chk("ram_en", bus.ram_en, own != 0);
    if (own != 0) begin
      chk("ram_we", bus.ram_we, we);
      chk("ram_addr", bus.ram_addr, a);
      if (we) chk("ram_wdata", bus.ram_wdata, wd);
    end
    chk("vga_rvalid", bus.vga_rvalid, pend == 1 && !rst);
    chk("r0_rvalid", bus.r0_rvalid, pend == 2 && !rst);
    chk("r1_rvalid", bus.r1_rvalid, pend == 3 && !rst);
    if (pend == 1 && !rst) chk("vga_rdata", bus.vga_rdata, pdata);
    if (pend == 2 && !rst) chk("r0_rdata", bus.r0_rdata, pdata);
    if (pend == 3 && !rst) chk("r1_rdata", bus.r1_rdata, pdata);
    chk("r0_starve", bus.r0_starve, cnt0 >= LIMIT && !rst);
    chk("r1_starve", bus.r1_starve, cnt1 >= LIMIT && !rst);
`ifdef FB_DOUBLE_BUFFER_EN
    chk("front_sel", bus.front_sel, m_front);
    chk("swap_done", bus.swap_done, m_done);
`endif
    g0 = (own == 2);
    g1 = (own == 3);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      pend = 0;
      if (own != 0) begin
        if (we) shadow[a] = wd;
        else begin
          pend  = own;
          pdata = shadow_rd(a);
        end
      end
      if (own == 2) pref = 1;
      if (own == 3) pref = 0;
      cnt0 = (bus.r0_req && own != 2) ? ((cnt0 + 1 > LIMIT) ? LIMIT : cnt0 + 1) : 0;
      cnt1 = (bus.r1_req && own != 3) ? ((cnt1 + 1 > LIMIT) ? LIMIT : cnt1 + 1) : 0;
`ifdef FB_DOUBLE_BUFFER_EN
      m_done = 0;
      if (bus.swap_req) m_pend = 1;
      if (bus.frame_start && m_pend == 1) begin
        m_front = 1 - m_front;
        m_pend  = 0;
        m_done  = 1;
      end
`endif
    end
    #1;
  endtask

  task automatic set_r0(bit req, bit we, int row, int col, logic [DW-1:0] wd);
    bus.r0_req = req; bus.r0_we = we;
    bus.r0_row = ROW_W'(row); bus.r0_col = COL_W'(col); bus.r0_wdata = wd;
  endtask

  task automatic set_r1(bit req, bit we, int row, int col, logic [DW-1:0] wd);
    bus.r1_req = req; bus.r1_we = we;
    bus.r1_row = ROW_W'(row); bus.r1_col = COL_W'(col); bus.r1_wdata = wd;
  endtask

  initial begin
    model_reset();
    g0 = 1'b0; g1 = 1'b0;
    rst = 1'b1;
    bus.vga_rd = 1'b0; bus.vga_row = '0; bus.vga_col = '0;
    set_r0(0, 0, 0, 0, '0);
    set_r1(0, 0, 0, 0, '0);
`ifdef FB_DOUBLE_BUFFER_EN
    bus.swap_req = 1'b0; bus.frame_start = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    step();

    // VGA priority over a pending r0 write
    bus.vga_rd = 1'b1; bus.vga_row = 9'd5; bus.vga_col = 10'd10;
    set_r0(1, 1, 2, 3, 12'hABC);
    step();
    bus.vga_rd = 1'b0;
    step();
    set_r0(0, 0, 0, 0, '0);
    step();

    // Round robin between two reading requesters
    set_r0(1, 0, 2, 3, '0);
    set_r1(1, 0, 7, 8, '0);
    repeat (4) step();
    set_r0(0, 0, 0, 0, '0);
    set_r1(0, 0, 0, 0, '0);
    step();

    // Write then read back at the far corner
    set_r1(1, 1, 479, 639, 12'hF00);
    step();
    set_r1(1, 0, 479, 639, '0);
    step();
    set_r1(0, 0, 0, 0, '0);
    step();

    // Starvation under continuous VGA reads
    bus.vga_rd = 1'b1; bus.vga_row = 9'd100; bus.vga_col = 10'd200;
    set_r0(1, 0, 1, 1, '0);
    repeat (LIMIT + 1) step();
    bus.vga_rd = 1'b0;
    step();
    set_r0(0, 0, 0, 0, '0);
    step();

    // Reset arrives the cycle after a granted read
    set_r0(1, 0, 4, 4, '0);
    step();
    set_r0(0, 0, 0, 0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_r0(1, 0, 5, 5, '0);
    set_r1(1, 0, 6, 6, '0);
    step();
    step();
    set_r0(0, 0, 0, 0, '0);
    set_r1(0, 0, 0, 0, '0);
    step();

    // Randomized traffic honouring the hold-until-grant rule
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(63) == 0);
      bus.vga_rd  = ($urandom_range(2) == 0);
      bus.vga_row = ROW_W'($urandom_range(3));
      bus.vga_col = COL_W'($urandom_range(3));
      if (!bus.r0_req || g0)
        set_r0($urandom_range(2) != 0, $urandom_range(1), $urandom_range(3), $urandom_range(3), DW'($urandom));
      else if ($urandom_range(19) == 0)
        bus.r0_req = 1'b0;
      if (!bus.r1_req || g1)
        set_r1($urandom_range(2) != 0, $urandom_range(1), $urandom_range(3), $urandom_range(3), DW'($urandom));
      else if ($urandom_range(19) == 0)
        bus.r1_req = 1'b0;
      step();
    end
    rst = 1'b0;
    bus.vga_rd = 1'b0;
    set_r0(0, 0, 0, 0, '0);
    set_r1(0, 0, 0, 0, '0);
    step();

`ifdef FB_DOUBLE_BUFFER_EN
    // Bank swap: request, then frame start ten cycles later
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.vga_rd = i[0];
      set_r0(1, 1, i, i, DW'(i));
      step();
    end
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.vga_rd = i[0];
      bus.vga_row = 9'd5; bus.vga_col = 10'd10;
      set_r0(1, i[1], 3, 3, 12'h0F0);
      step();
    end
    bus.vga_rd = 1'b0;
    set_r0(0, 0, 0, 0, '0);
    step();
    chk("front_sel_after_swap", bus.front_sel, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Arbitrates one single-port synchronous pixel RAM between the VGA scan-out reader and two game-logic requesters (r0, r1), e.g. map renderer and sprite/tank drawer.
- VGA reads have absolute priority; requesters share the remaining cycles (horizontal and vertical blanking) round-robin, with read/write support, read-return tagging and starvation flags.

Parameters:
ROW_W, 9, row address width (480 lines in a 512 space)
COL_W, 10, column address width (640 pixels in a 1024 space)
DW, 12, pixel width, rrrr_gggg_bbbb
STARVE_LIMIT, 800, wait cycles after which a requester's starve flag sets (one scan line)

Ports:
vga_clk  in  1  pixel clock (25 MHz); all logic on rising edge
rst  in  1  synchronous reset, active high
vga_rd  in  1  VGA read request for the current cycle (active-display window)
vga_row  in  ROW_W  VGA row address
vga_col  in  COL_W  VGA column address
vga_rdata  out  DW  pixel returned to the VGA path
vga_rvalid  out  1  vga_rdata valid; one cycle after the vga_rd cycle
r0_req  in  1  requester 0 access request; hold it and r0_we/row/col/wdata stable until r0_gnt
r0_we  in  1  1 = write, 0 = read
r0_row  in  ROW_W  row address
r0_col  in  COL_W  column address
r0_wdata  in  DW  write pixel
r0_gnt  out  1  combinational; access performed this cycle
r0_rvalid  out  1  read data valid (cycle after the granted read)
r0_rdata  out  DW  read data
r0_starve  out  1  registered; set when waiting longer than STARVE_LIMIT
r1_*  (same set as r0_*, for requester 1)
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ROW_W+COL_W  {row, col}
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, 1-cycle latency

Behaviour:
- Slot owner each cycle, combinational from inputs and state:
  - rst=1 → none.
  - vga_rd=1 → VGA.
  - Else r0_req&r1_req → the requester selected by rr_ptr.
  - Else the single requesting one.
  - Else none.
- VGA slot: ram_en=1, ram_we=0, ram_addr={vga_row,vga_col}. Both gnt=0.
- Requester slot: ram_en=1, ram_we=rN_we, ram_addr={rN_row,rN_col}, ram_wdata=rN_wdata, rN_gnt=1.
- No slot: ram_en=0, ram_we=0. ram_addr/ram_wdata are don't-care.
- rr_ptr (1 bit, reset 0 = r0 preferred):
  - After any requester grant, rr_ptr points to the other requester.
  - Unchanged on VGA or idle cycles.
- Read-return tag: a 2-bit register rd_tag (reset NONE; values NONE/VGA/R0/R1) records the owner of each read slot.
  - Next cycle, the matching *_rvalid=1 and its *_rdata=ram_rdata.
  - Non-matching rvalids are 0. rdata outputs are don't-care when rvalid=0.
- Writes produce no rvalid. Write-then-read of the same address on consecutive granted cycles returns the new data (RAM write-first is required).
- Wait counters: waitN (width clog2(STARVE_LIMIT+1), saturating).
  - Increments each cycle rN_req=1 and rN_gnt=0.
  - Clears on grant or when rN_req=0.
  - rN_starve is registered: set when waitN reaches STARVE_LIMIT, cleared on the grant cycle's next edge.
- Reset values: vga_rvalid, r0_rvalid, r1_rvalid, r0_starve, r1_starve = 0; rd_tag=NONE; rr_ptr=0; counters 0.
- rst asserted mid-operation: a read issued in the cycle before reset produces no rvalid.
- Simultaneous events:
  - vga_rd with both reqs → VGA wins; requesters' counters advance.
  - Dropping req before gnt is legal; its counter clears.
- Latency: requester access takes 1 cycle minimum from req when the slot is free. Read data arrives 1 cycle after gnt.

Optional Feature:
- Macro FB_DOUBLE_BUFFER_EN.
- When defined:
  - Adds inputs swap_req (pulse) and frame_start (pulse at VGA frame begin), and outputs front_sel and swap_done.
  - ram_addr widens by 1 MSB: VGA uses front_sel, requesters use ~front_sel.
  - swap_req sets sticky swap_pend. On frame_start with swap_pend, front_sel toggles, swap_pend clears, and swap_done pulses for 1 cycle.
  - Reset: front_sel=0, swap_pend=0, swap_done=0.
- When undefined: those ports are absent; ram_addr is ROW_W+COL_W bits.

Test Plan:
- VGA priority: vga_rd=1 @ row 5, col 10 with r0_req=1 (write) → ram_addr=0x0140A, r0_gnt=0. Next cycle vga_rd=0 → r0_gnt=1, ram_we=1.
- Round robin: r0,r1 both request reads for 4 free cycles → grants r0,r1,r0,r1. Each rvalid 1 cycle after its gnt with the matching ram_rdata.
- Write/read-back: r1 writes 0xF00 to (479,639), then reads it → r1_rvalid=1, r1_rdata=0xF00; r0_rvalid stays 0.
- Starvation: vga_rd held high 801 cycles with r0_req=1 → r0_starve=1 after STARVE_LIMIT cycles. First free cycle → r0_gnt=1, r0_starve=0 next cycle.
- Reset mid-read: r0 granted a read, rst=1 the next cycle → r0_rvalid=0, rr_ptr=0, all outputs at reset values.
- FB_DOUBLE_BUFFER_EN: swap_req then frame_start 10 cycles later → front_sel 0→1, swap_done pulses once. VGA ram_addr MSB=1, requester MSB=0.
